// File: rtl/key_pkg.sv
// Shared definitions for the key conditioning front end.
//   key_state_t : per-key debounce FSM state
//   KEY_*       : bit positions of each command key within KEY / key_level
package key_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam int unsigned KEY_INC   = 0;
  localparam int unsigned KEY_DEC   = 1;
  localparam int unsigned KEY_START = 2;
  localparam int unsigned KEY_STOP  = 3;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM and qualification counter.
// Optional macro KEY_AUTOREPEAT_EN exposes the FSM state for the repeat logic.
//   clk, rst    : clock, asynchronous active-high reset
//   key_n       : raw key, active-low, asynchronous to clk
//   press_qual  : high during the cycle whose closing edge accepts a press
//   state       : current FSM state (only with KEY_AUTOREPEAT_EN)
//   level       : registered debounced level, 1 = pressed
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  output logic       press_qual,
`ifdef KEY_AUTOREPEAT_EN
  output key_state_t state,
`endif
  output logic       level
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  key_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_d;

  // Synchroniser idles at 1 (released) so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= key_n;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      level   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level   <= level_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RELEASED: begin
        if (!s2) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (s2)                   state_d = RELEASED;
        else if (cnt_q == CNT_LAST) state_d = PRESSED;
        else                      cnt_d   = cnt_q + CNT_W'(1);
      end
      PRESSED: begin
        if (s2) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!s2)                  state_d = PRESSED;
        else if (cnt_q == CNT_LAST) state_d = RELEASED;
        else                      cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = RELEASED;
    endcase
  end

  // level is registered from the next state so it moves on the same edge as the FSM.
  always_comb begin
    level_d    = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    press_qual = (state_q == PRESS_WAIT) && !s2 && (cnt_q == CNT_LAST);
  end

`ifdef KEY_AUTOREPEAT_EN
  assign state = state_q;
`endif

endmodule

// File: rtl/key_conditioner.sv
// Key front end: four debounced channels, command interlocks and registered
// single-cycle command pulses. Optional macro KEY_AUTOREPEAT_EN adds
// auto-repeat on the increase/decrease keys.
//   clk, rst      : clock, asynchronous active-high reset
//   KEY[3:0]      : raw keys, active-low ([0]=inc, [1]=dec, [2]=start, [3]=stop)
//   btn_*         : one-cycle active-high command pulses
//   key_level     : debounced level per key, 1 = pressed
module key_conditioner
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES     = 1000000,
  parameter int unsigned REPEAT_DELAY_CYCLES = 25000000,
  parameter int unsigned REPEAT_RATE_CYCLES  = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] KEY,
  output logic       btn_increase,
  output logic       btn_decrease,
  output logic       btn_start,
  output logic       btn_stop,
  output logic [3:0] key_level
);

  logic [3:0] press_qual;
  logic [1:0] rep_fire;
  logic [3:0] qual;

`ifdef KEY_AUTOREPEAT_EN
  key_state_t ch_state [4];
`endif

  for (genvar i = 0; i < 4; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .key_n     (KEY[i]),
      .press_qual(press_qual[i]),
`ifdef KEY_AUTOREPEAT_EN
      .state     (ch_state[i]),
`endif
      .level     (key_level[i])
    );
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                                    REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST = RPT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_RATE_LAST  = RPT_W'(REPEAT_RATE_CYCLES - 1);

  logic [RPT_W-1:0] rcnt   [2];
  logic [1:0]       rfirst;

  for (genvar i = 0; i < 2; i++) begin : g_rpt
    // Counter starts at 0 on the edge that emits the initial pulse; the
    // first repeat uses the delay, later ones the rate.
    always_comb begin
      rep_fire[i] = (ch_state[i] == PRESSED) &&
                    (rcnt[i] == (rfirst[i] ? RPT_DELAY_LAST : RPT_RATE_LAST));
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rcnt[i]   <= '0;
        rfirst[i] <= 1'b1;
      end else if (ch_state[i] == PRESSED) begin
        if (rep_fire[i]) begin
          rcnt[i]   <= '0;
          rfirst[i] <= 1'b0;
        end else begin
          rcnt[i] <= rcnt[i] + RPT_W'(1);
        end
      end else if (ch_state[i] != RELEASE_WAIT) begin
        rcnt[i]   <= '0;
        rfirst[i] <= 1'b1;
      end
    end
  end
`else
  assign rep_fire = '0;
`endif

  always_comb begin
    qual            = press_qual;
    qual[KEY_INC]   = press_qual[KEY_INC] | rep_fire[KEY_INC];
    qual[KEY_DEC]   = press_qual[KEY_DEC] | rep_fire[KEY_DEC];
  end

  // Interlocks are resolved before the output flops so the pulse lands on the
  // same edge the channel accepts the press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_increase <= 1'b0;
      btn_decrease <= 1'b0;
      btn_start    <= 1'b0;
      btn_stop     <= 1'b0;
    end else begin
      btn_increase <= qual[KEY_INC] & ~qual[KEY_DEC];
      btn_decrease <= qual[KEY_DEC] & ~qual[KEY_INC];
      btn_start    <= qual[KEY_START] & ~qual[KEY_STOP];
      btn_stop     <= qual[KEY_STOP];
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] KEY;
  logic       btn_increase, btn_decrease, btn_start, btn_stop;
  logic [3:0] key_level;

  int tot = 0;
  int bad = 0;
  int n_inc = 0, n_dec = 0, n_start = 0, n_stop = 0;
  int base_inc, base_dec, base_start, base_stop;
  logic seen_kl1;
  logic exp_b;

  key_conditioner #(
    .DEBOUNCE_CYCLES    (4),
    .REPEAT_DELAY_CYCLES(10),
    .REPEAT_RATE_CYCLES (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .KEY         (KEY),
    .btn_increase(btn_increase),
    .btn_decrease(btn_decrease),
    .btn_start   (btn_start),
    .btn_stop    (btn_stop),
    .key_level   (key_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (btn_increase) n_inc++;
    if (btn_decrease) n_dec++;
    if (btn_start)    n_start++;
    if (btn_stop)     n_stop++;
    if (key_level[1]) seen_kl1 = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tot++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    base_inc = n_inc; base_dec = n_dec; base_start = n_start; base_stop = n_stop;
  endtask

  initial begin
    KEY = 4'hF;
    rst = 1'b1;
    seen_kl1 = 1'b0;
    tick(3);
    chk("rst_btns", {btn_increase, btn_decrease, btn_start, btn_stop}, 4'b0000);
    chk("rst_level", key_level, 4'b0000);
    rst = 1'b0;
    tick(3);

    // 1: clean press of increase
    snap();
    KEY[0] = 1'b0;
    tick(6);
    chk("t1_e6_inc", btn_increase, 1'b0);
    chk("t1_e6_lvl", key_level, 4'b0000);
    tick(1);
    chk("t1_e7_inc", btn_increase, 1'b1);
    chk("t1_e7_lvl", key_level, 4'b0001);
    chk("t1_e7_others", {btn_decrease, btn_start, btn_stop}, 3'b000);
    tick(1);
    chk("t1_e8_inc", btn_increase, 1'b0);
    tick(12);
    KEY[0] = 1'b1;
    tick(6);
    chk("t1_rel6_lvl", key_level[0], 1'b1);
    tick(1);
    chk("t1_rel7_lvl", key_level[0], 1'b0);
    chk("t1_inc_cnt", n_inc - base_inc, 1);
    chk("t1_other_cnt", (n_dec - base_dec) + (n_start - base_start) + (n_stop - base_stop), 0);

    // 2: bouncing decrease never qualifies
    snap();
    seen_kl1 = 1'b0;
    KEY[1] = 1'b0; tick(3);
    KEY[1] = 1'b1; tick(1);
    KEY[1] = 1'b0; tick(2);
    KEY[1] = 1'b1; tick(1);
    KEY[1] = 1'b0; tick(3);
    KEY[1] = 1'b1; tick(12);
    chk("t2_dec_cnt", n_dec - base_dec, 0);
    chk("t2_lvl_seen", seen_kl1, 1'b0);

    // 3: start and stop together -> stop wins
    snap();
    KEY[3:2] = 2'b00;
    tick(6);
    chk("t3_e6_stop", btn_stop, 1'b0);
    tick(1);
    chk("t3_e7_stop", btn_stop, 1'b1);
    chk("t3_e7_start", btn_start, 1'b0);
    tick(3);
    KEY = 4'hF;
    tick(12);
    chk("t3_start_cnt", n_start - base_start, 0);
    chk("t3_stop_cnt", n_stop - base_stop, 1);

    // 4a: inc and dec together -> neither emitted
    snap();
    KEY[1:0] = 2'b00;
    tick(7);
    chk("t4a_e7_btns", {btn_increase, btn_decrease}, 2'b00);
    chk("t4a_e7_lvl", key_level[1:0], 2'b11);
    tick(3);
    KEY = 4'hF;
    tick(12);
    chk("t4a_cnt", (n_inc - base_inc) + (n_dec - base_dec), 0);

    // 4b: dec first, inc one cycle later
    snap();
    KEY[1] = 1'b0;
    tick(1);
    KEY[0] = 1'b0;
    tick(6);
    chk("t4b_e7", {btn_increase, btn_decrease}, 2'b01);
    tick(1);
    chk("t4b_e8", {btn_increase, btn_decrease}, 2'b10);
    tick(1);
    KEY = 4'hF;
    tick(12);
    chk("t4b_inc_cnt", n_inc - base_inc, 1);
    chk("t4b_dec_cnt", n_dec - base_dec, 1);

    // 5: reset during debounce, key still held
    KEY[0] = 1'b0;
    tick(4);
    rst = 1'b1;
    #1;
    chk("t5_rst_btns", {btn_increase, btn_decrease, btn_start, btn_stop}, 4'b0000);
    chk("t5_rst_lvl", key_level, 4'b0000);
    tick(2);
    chk("t5_rst_hold", {btn_increase, key_level}, 5'b0);
    rst = 1'b0;
    tick(6);
    chk("t5_e6_inc", btn_increase, 1'b0);
    tick(1);
    chk("t5_e7_inc", btn_increase, 1'b1);
    chk("t5_e7_lvl", key_level[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_clr_inc", btn_increase, 1'b0);
    chk("t5_clr_lvl", key_level[0], 1'b0);
    KEY = 4'hF;
    tick(2);
    rst = 1'b0;
    tick(3);

    // 6: long hold of increase (repeat when enabled), long hold of start
    snap();
    KEY[0] = 1'b0;
    for (int e = 1; e <= 45; e++) begin
      tick(1);
`ifdef KEY_AUTOREPEAT_EN
      exp_b = (e == 7) || (e >= 17 && e <= 42 && ((e - 17) % 5) == 0);
`else
      exp_b = (e == 7);
`endif
      chk($sformatf("t6_inc_e%0d", e), btn_increase, exp_b);
      if (e == 40) KEY[0] = 1'b1;
    end
    tick(10);
`ifdef KEY_AUTOREPEAT_EN
    chk("t6_inc_cnt", n_inc - base_inc, 7);
`else
    chk("t6_inc_cnt", n_inc - base_inc, 1);
`endif
    KEY[2] = 1'b0;
    tick(40);
    KEY = 4'hF;
    tick(12);
    chk("t6_start_cnt", n_start - base_start, 1);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
